// File: rtl/risc_core.sv
// Single-cycle 32-bit load/store core: combinational fetch/decode/execute from imem[pc],
// with all architectural state committed at the rising edge while running.
module risc_core #(
    parameter int RFW = 5,
    parameter int IMW = 4,
    parameter int DW  = 32,
    parameter int IW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           imem_we,
    input  logic [IMW-1:0] imem_addr,
    input  logic [IW-1:0]  imem_wdata,
    input  logic [RFW-1:0] dbg_addr,
    output logic [DW-1:0]  dbg_data,
    output logic [IMW-1:0] pc,
    output logic           halted
);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_SLT  = 6'h06;
    localparam logic [5:0] OP_SLL  = 6'h07;
    localparam logic [5:0] OP_SRL  = 6'h08;
    localparam logic [5:0] OP_ADDI = 6'h09;
    localparam logic [5:0] OP_LUI  = 6'h0A;
    localparam logic [5:0] OP_LW   = 6'h0B;
    localparam logic [5:0] OP_SW   = 6'h0C;
    localparam logic [5:0] OP_BEQ  = 6'h0D;
    localparam logic [5:0] OP_BNE  = 6'h0E;
    localparam logic [5:0] OP_JMP  = 6'h0F;
    localparam logic [5:0] OP_HALT = 6'h3F;

    logic [IW-1:0] imem [0:(1<<IMW)-1];
    logic [DW-1:0] rf   [0:(1<<RFW)-1];
    logic [DW-1:0] dmem [0:(1<<IMW)-1];

    logic [IW-1:0]  instr;
    logic [5:0]     op;
    logic [RFW-1:0] rd, rs1, rs2;
    logic [15:0]    imm;
    logic [DW-1:0]  sext, rv1, rv2, rvd;
    logic [IMW-1:0] ea, br_target;

    logic [DW-1:0]  wb_data;
    logic           wb_en, dm_we, halt_next;
    logic [IMW-1:0] pc_next;

    assign instr = imem[pc];
    assign op    = instr[31:26];
    assign rd    = instr[21 +: RFW];
    assign rs1   = instr[16 +: RFW];
    assign rs2   = instr[11 +: RFW];
    assign imm   = instr[15:0];
    assign sext  = {{(DW-16){imm[15]}}, imm};

    assign rv1 = (rs1 == '0) ? '0 : rf[rs1];
    assign rv2 = (rs2 == '0) ? '0 : rf[rs2];
    assign rvd = (rd  == '0) ? '0 : rf[rd];

    // Only the low IMW bits of the sum matter, so add the truncated operands directly.
    assign ea        = rv1[IMW-1:0] + imm[IMW-1:0];
    assign br_target = pc + IMW'(1) + imm[IMW-1:0];

    assign dbg_data = (dbg_addr == '0) ? '0 : rf[dbg_addr];

    always_comb begin
        wb_en     = 1'b0;
        wb_data   = '0;
        dm_we     = 1'b0;
        halt_next = 1'b0;
        pc_next   = pc + IMW'(1);
        case (op)
            OP_ADD:  begin wb_en = 1'b1; wb_data = rv1 + rv2; end
            OP_SUB:  begin wb_en = 1'b1; wb_data = rv1 - rv2; end
            OP_AND:  begin wb_en = 1'b1; wb_data = rv1 & rv2; end
            OP_OR:   begin wb_en = 1'b1; wb_data = rv1 | rv2; end
            OP_XOR:  begin wb_en = 1'b1; wb_data = rv1 ^ rv2; end
            OP_SLT:  begin wb_en = 1'b1; wb_data = ($signed(rv1) < $signed(rv2)) ? DW'(1) : '0; end
            OP_SLL:  begin wb_en = 1'b1; wb_data = rv1 << rv2[4:0]; end
            OP_SRL:  begin wb_en = 1'b1; wb_data = rv1 >> rv2[4:0]; end
            OP_ADDI: begin wb_en = 1'b1; wb_data = rv1 + sext; end
            OP_LUI:  begin wb_en = 1'b1; wb_data = DW'(imm) << 16; end
            OP_LW:   begin wb_en = 1'b1; wb_data = dmem[ea]; end
            OP_SW:   dm_we = 1'b1;
            OP_BEQ:  if (rvd == rv1) pc_next = br_target;
            OP_BNE:  if (rvd != rv1) pc_next = br_target;
            OP_JMP:  pc_next = imm[IMW-1:0];
            OP_HALT: begin halt_next = 1'b1; pc_next = pc; end
            OP_NOP:  ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            halted <= 1'b0;
            for (int i = 0; i < (1 << RFW); i++) rf[i] <= '0;
            for (int i = 0; i < (1 << IMW); i++) dmem[i] <= '0;
        end else if (start && !halted) begin
            pc <= pc_next;
            if (halt_next) halted <= 1'b1;
            if (wb_en && rd != '0) rf[rd] <= wb_data;
            if (dm_we) dmem[ea] <= rvd;
        end
    end

    // Program memory survives reset; a write to the word at pc takes effect on the next fetch.
    always_ff @(posedge clk) begin
        if (!rst && imem_we) imem[imem_addr] <= imem_wdata;
    end

endmodule

// File: tb/tb_risc_core.sv
// Directed bench for risc_core: programs small routines through the load port and
// checks registers, pc and halt against hand-computed values.
module tb_risc_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_we = 1'b0;
    logic [3:0]  imem_addr = '0;
    logic [31:0] imem_wdata = '0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_data;
    logic [3:0]  pc;
    logic        halted;

    int compared = 0;
    int mismatched = 0;
    logic [31:0] prog [16];

    localparam logic [31:0] HALT = 32'hFC00_0000;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    risc_core dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic logic [31:0] er(input logic [5:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] r, input logic [31:0] exp);
        dbg_addr = r;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < 16; i++) prog[i] = w;
    endtask

    task automatic load_prog();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            imem_we = 1'b1;
            imem_addr = 4'(i);
            imem_wdata = prog[i];
        end
        @(negedge clk);
        imem_we = 1'b0;
    endtask

    task automatic run_to_halt(input string tag);
        int n = 0;
        start = 1'b1;
        while (!halted && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    initial begin
        // Reset and stall
        do_reset();
        cycles(5);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        for (int r = 0; r < 32; r++) chk_reg($sformatf("rst_r%0d", r), 5'(r), 32'd0);

        // ALU sequence
        fill(HALT);
        prog[0] = ei(6'h09, 1, 0, 16'd5);
        prog[1] = ei(6'h09, 2, 0, 16'hFFFD);
        prog[2] = er(6'h01, 3, 1, 2);
        prog[3] = er(6'h02, 4, 1, 2);
        prog[4] = er(6'h06, 5, 2, 1);
        load_prog();
        start = 1'b1;
        cycles(6);
        check("alu_halted", 32'(halted), 32'd1);
        check("alu_pc", 32'(pc), 32'd5);
        chk_reg("alu_r1", 1, 32'd5);
        chk_reg("alu_r2", 2, 32'hFFFF_FFFD);
        chk_reg("alu_r3", 3, 32'd2);
        chk_reg("alu_r4", 4, 32'd8);
        chk_reg("alu_r5", 5, 32'd1);
        cycles(3);
        check("alu_pc_held", 32'(pc), 32'd5);
        do_reset();
        check("rst_clears_halt", 32'(halted), 32'd0);
        chk_reg("rst_clears_r4", 4, 32'd0);

        // Logic and shifts
        fill(HALT);
        prog[0]  = ei(6'h09, 1, 0, 16'h00F0);
        prog[1]  = ei(6'h09, 2, 0, 16'h00FF);
        prog[2]  = er(6'h03, 3, 1, 2);
        prog[3]  = er(6'h04, 4, 1, 2);
        prog[4]  = er(6'h05, 5, 1, 2);
        prog[5]  = ei(6'h09, 6, 0, 16'd4);
        prog[6]  = er(6'h07, 7, 2, 6);
        prog[7]  = ei(6'h09, 8, 0, 16'hFFF0);
        prog[8]  = er(6'h08, 9, 8, 6);
        prog[9]  = er(6'h06, 10, 1, 8);
        prog[10] = ei(6'h09, 12, 0, 16'd36);
        prog[11] = er(6'h07, 11, 2, 12);
        prog[12] = ei(6'h3A, 13, 0, 16'd1);
        load_prog();
        run_to_halt("log_halt");
        check("log_pc", 32'(pc), 32'd13);
        chk_reg("and", 3, 32'h0000_00F0);
        chk_reg("or", 4, 32'h0000_00FF);
        chk_reg("xor", 5, 32'h0000_000F);
        chk_reg("sll", 7, 32'h0000_0FF0);
        chk_reg("srl", 9, 32'h0FFF_FFFF);
        chk_reg("slt_neg", 10, 32'd0);
        chk_reg("sll_shamt5", 11, 32'h0000_0FF0);
        chk_reg("bad_op_nop", 13, 32'd0);

        // Memory
        do_reset();
        fill(HALT);
        prog[0] = ei(6'h09, 1, 0, 16'd7);
        prog[1] = ei(6'h0C, 1, 0, 16'd3);
        prog[2] = ei(6'h0B, 6, 0, 16'd3);
        prog[3] = ei(6'h0A, 7, 0, 16'h1234);
        prog[4] = ei(6'h09, 8, 0, 16'd20);
        prog[5] = ei(6'h0B, 9, 8, 16'hFFFF);
        prog[6] = ei(6'h0B, 10, 0, 16'd4);
        load_prog();
        run_to_halt("mem_halt");
        chk_reg("lw", 6, 32'd7);
        chk_reg("lui", 7, 32'h1234_0000);
        chk_reg("lw_ea_wrap", 9, 32'd7);
        chk_reg("lw_other", 10, 32'd0);

        // Branch and jump
        do_reset();
        fill(HALT);
        prog[0] = ei(6'h09, 1, 0, 16'd1);
        prog[1] = ei(6'h0E, 1, 0, 16'd1);
        prog[2] = ei(6'h09, 2, 0, 16'd9);
        prog[3] = ei(6'h0F, 0, 0, 16'd5);
        prog[4] = ei(6'h09, 3, 0, 16'd1);
        load_prog();
        run_to_halt("br_halt");
        check("br_pc", 32'(pc), 32'd5);
        chk_reg("bne_skip", 2, 32'd0);
        chk_reg("jmp_skip", 3, 32'd0);

        do_reset();
        fill(HALT);
        prog[0] = ei(6'h09, 1, 0, 16'd2);
        prog[1] = ei(6'h0D, 1, 0, 16'd5);
        prog[2] = ei(6'h0D, 0, 0, 16'd2);
        prog[3] = ei(6'h09, 4, 0, 16'd1);
        prog[4] = ei(6'h09, 4, 0, 16'd1);
        prog[5] = ei(6'h0E, 1, 1, 16'd3);
        prog[6] = ei(6'h09, 5, 0, 16'd3);
        load_prog();
        run_to_halt("beq_halt");
        check("beq_pc", 32'(pc), 32'd7);
        chk_reg("beq_taken", 4, 32'd0);
        chk_reg("bne_not_taken", 5, 32'd3);

        // r0, pc wrap, stall, reset mid-run
        do_reset();
        fill(NOP);
        prog[0] = ei(6'h09, 0, 0, 16'd4);
        prog[1] = ei(6'h09, 1, 1, 16'd1);
        load_prog();
        start = 1'b1;
        cycles(16);
        check("wrap_pc", 32'(pc), 32'd0);
        chk_reg("r0_zero", 0, 32'd0);
        chk_reg("wrap_r1", 1, 32'd1);
        cycles(3);
        check("run_pc", 32'(pc), 32'd3);
        start = 1'b0;
        cycles(3);
        check("stall_pc", 32'(pc), 32'd3);
        chk_reg("stall_r1", 1, 32'd2);
        start = 1'b1;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("midrst_pc", 32'(pc), 32'd0);
        chk_reg("midrst_r1", 1, 32'd0);
        cycles(2);
        check("post_rst_pc", 32'(pc), 32'd2);
        chk_reg("imem_kept", 1, 32'd1);
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
